// File: rtl/quad_encoder_emulator_pkg.sv
// quad_encoder_emulator_pkg: shared types, constants and decode helpers for the encoder emulator.
package quad_encoder_emulator_pkg;
   localparam int POS_W = 14;
   localparam logic [11:0] PPR_DEFAULT = 12'd1024;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   function automatic logic [11:0] ppr_from_pr(input logic [3:0] pr);
      return (pr == 4'b0001) ? 12'd2048 :
             (pr == 4'b0010) ? 12'd500  :
             (pr == 4'b0011) ? 12'd360  :
             (pr == 4'b1001) ? 12'd600  : PPR_DEFAULT;
   endfunction

   // Gray sequence 00,01,11,10 so that exactly one channel toggles per edge
   function automatic logic [1:0] phase_ab(input logic [1:0] ph);
      return {ph[1], ph[1] ^ ph[0]};
   endfunction
endpackage

// File: rtl/quad_encoder_emulator_timer.sv
// qe_edge_timer: counts 0..period-1 and ticks on terminal count, re-sampling period on every tick.
module qe_edge_timer #(
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr,
   input  logic                en,
   input  logic [PERIOD_W-1:0] period,
   output logic                tick
);
   logic [PERIOD_W-1:0] timer_q, per_q, per_in;

   assign per_in = (period == '0) ? PERIOD_W'(1) : period;
   assign tick   = en & (timer_q == per_q - PERIOD_W'(1));

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         timer_q <= '0;
         per_q   <= PERIOD_W'(1);
      end else if (clr || tick) begin
         timer_q <= '0;
         per_q   <= per_in;
      end else if (en) begin
         timer_q <= timer_q + PERIOD_W'(1);
      end
endmodule

// File: rtl/quad_encoder_emulator.sv
// quad_encoder_emulator: generates quadrature A/B and index Z from a commanded edge period, direction and count.
module quad_encoder_emulator
   import quad_encoder_emulator_pkg::*;
#(
   parameter int PERIOD_W = 16,
   parameter int COUNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          PR,
   input  logic                dir,
   input  logic [PERIOD_W-1:0] period,
   input  logic [COUNT_W-1:0]  count,
   input  logic                start,
   input  logic                stop,
   output logic                A,
   output logic                B,
   output logic                Z,
   output logic [POS_W-1:0]    position,
   output logic                busy,
   output logic                done
);
   state_t               state_q, state_d;
   logic [11:0]          ppr_q, ppr_d, ppr_dec;
   logic                 dir_q, tick, last, step, accept, done_d;
   logic [COUNT_W-1:0]   count_q, edges_q;
   logic [POS_W-1:0]     pos_d, max_pos;

   assign ppr_dec = ppr_from_pr(PR);
   assign max_pos = POS_W'({ppr_q, 2'b00}) - POS_W'(1);
   assign accept  = (state_q == IDLE) && start;
   assign last    = (count_q != '0) && (edges_q == count_q - COUNT_W'(1));
   // the final edge still goes out when stop lands on the same cycle
   assign step    = tick & (~stop | last);
   assign busy    = (state_q == RUN);

   qe_edge_timer #(.PERIOD_W(PERIOD_W)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (accept),
      .en     (state_q == RUN),
      .period (period),
      .tick   (tick)
   );

   always_comb begin
      state_d = state_q;
      ppr_d   = ppr_q;
      pos_d   = position;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         ppr_d   = ppr_dec;
         pos_d   = (ppr_dec != ppr_q) ? '0 : position;
         state_d = start ? RUN : IDLE;
      end else begin
         if (step)
            pos_d = dir_q ? ((position == '0) ? max_pos : position - POS_W'(1))
                          : ((position == max_pos) ? '0 : position + POS_W'(1));
         if ((step && last) || stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ppr_q    <= PPR_DEFAULT;
         position <= '0;
         A        <= 1'b0;
         B        <= 1'b0;
         Z        <= 1'b1;
         done     <= 1'b0;
         dir_q    <= 1'b0;
         count_q  <= '0;
         edges_q  <= '0;
      end else begin
         ppr_q    <= ppr_d;
         position <= pos_d;
         {A, B}   <= phase_ab(pos_d[1:0]);
         Z        <= (pos_d == '0);
         done     <= done_d;
         if (accept) begin
            dir_q   <= dir;
            count_q <= count;
            edges_q <= '0;
         end else if (step) begin
            edges_q <= edges_q + COUNT_W'(1);
         end
      end
endmodule
